// File: rtl/mem_stage_lat.sv
// MEM pipeline stage: stage register with stall/bubble/flush, fixed-latency SRAM read wait, sub-word load extraction.
// Optional misaligned-load detection (adel) is compiled in with `define MEM_ALIGN_CHK_EN.
module mem_stage_lat #(
  parameter int RD_LAT = 1,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall_this,
  input  logic              stall_next,
  input  logic [31:0]       in_pc,
  input  logic              in_mem_en,
  input  logic              in_mem_we,
  input  logic [2:0]        in_load_op,
  input  logic [1:0]        in_addr_lo,
  input  logic              in_rf_we,
  input  logic [REG_AW-1:0] in_rf_waddr,
  input  logic [31:0]       in_ex_result,
  input  logic              in_hi_we,
  input  logic              in_lo_we,
  input  logic [31:0]       data_sram_rdata,
  output logic              stallreq,
  output logic [31:0]       wb_pc,
  output logic              wb_rf_we,
  output logic [REG_AW-1:0] wb_rf_waddr,
  output logic [31:0]       wb_rf_wdata,
  output logic              wb_hi_we,
  output logic              wb_lo_we,
  output logic              fwd_load_pending,
  output logic              adel
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);
  localparam logic MULTI = (RD_LAT > 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;

  logic [31:0]       pc_r;
  logic              mem_en_r;
  logic              mem_we_r;
  logic [2:0]        load_op_r;
  logic [1:0]        addr_lo_r;
  logic              rf_we_r;
  logic [REG_AW-1:0] rf_waddr_r;
  logic [31:0]       ex_result_r;
  logic              hi_we_r;
  logic              lo_we_r;

  logic [0:0]        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              cap_r;

  logic              bubble_s;
  logic              load_s;
  logic              ld_s;
  logic              in_adel_s;
  logic              adel_s;
  logic              not_valid_s;
  logic              stallreq_s;
  logic [7:0]        byte_s;
  logic [15:0]       half_s;
  logic [31:0]       ld_data_s;

`ifdef MEM_ALIGN_CHK_EN
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    return ((op == OP_LW) && (a != 2'b00)) ||
           (((op == OP_LH) || (op == OP_LHU)) && a[0]);
  endfunction

  assign in_adel_s = in_mem_en & ~in_mem_we & misaligned(in_load_op, in_addr_lo);
  assign adel_s    = ld_s & misaligned(load_op_r, addr_lo_r);
`else
  assign in_adel_s = 1'b0;
  assign adel_s    = 1'b0;
`endif

  // A running wait freezes the register; otherwise stall_this/stall_next pick bubble, load or hold.
  assign bubble_s = rst | flush | ((state_r != ST_WAIT) & stall_this & ~stall_next);
  assign load_s   = ~rst & ~flush & (state_r != ST_WAIT) & ~stall_this;

  // Stage register: cleared on reset/flush/bubble, loaded from EX on capture, held otherwise.
  always_ff @(posedge clk) begin
    if (bubble_s) begin
      pc_r        <= 32'h0000_0000;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      load_op_r   <= 3'b000;
      addr_lo_r   <= 2'b00;
      rf_we_r     <= 1'b0;
      rf_waddr_r  <= {REG_AW{1'b0}};
      ex_result_r <= 32'h0000_0000;
      hi_we_r     <= 1'b0;
      lo_we_r     <= 1'b0;
    end else if (load_s) begin
      pc_r        <= in_pc;
      mem_en_r    <= in_mem_en;
      mem_we_r    <= in_mem_we;
      load_op_r   <= in_load_op;
      addr_lo_r   <= in_addr_lo;
      rf_we_r     <= in_rf_we;
      rf_waddr_r  <= in_rf_waddr;
      ex_result_r <= in_ex_result;
      hi_we_r     <= in_hi_we;
      lo_we_r     <= in_lo_we;
    end
  end

  // Read-latency FSM: cap_r marks the first cycle of a freshly captured load that must wait.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      cap_r   <= 1'b0;
    end else begin
      cap_r <= load_s & in_mem_en & ~in_mem_we & MULTI & ~in_adel_s;
      case (state_r)
        ST_IDLE: begin
          if (cap_r) begin
            state_r <= ST_WAIT;
            cnt_r   <= CNT_INIT;
          end
        end
        ST_WAIT: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign ld_s        = mem_en_r & ~mem_we_r;
  assign not_valid_s = ((state_r == ST_WAIT) & (cnt_r != {CNT_W{1'b0}})) |
                       ((state_r == ST_IDLE) & MULTI & cap_r);
  assign stallreq_s  = ld_s & not_valid_s;

  // Sub-word load extraction from the SRAM read word.
  always_comb begin
    byte_s = data_sram_rdata[{addr_lo_r, 3'b000} +: 8];
    half_s = addr_lo_r[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
    case (load_op_r)
      OP_LW:   ld_data_s = data_sram_rdata;
      OP_LB:   ld_data_s = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  ld_data_s = {24'h00_0000, byte_s};
      OP_LH:   ld_data_s = {{16{half_s[15]}}, half_s};
      OP_LHU:  ld_data_s = {16'h0000, half_s};
      default: ld_data_s = data_sram_rdata;
    endcase
  end

  assign stallreq         = stallreq_s;
  assign fwd_load_pending = stallreq_s;
  assign adel             = adel_s;
  assign wb_pc            = pc_r;
  assign wb_rf_we         = rf_we_r & ~stallreq_s & ~adel_s;
  assign wb_rf_waddr      = rf_waddr_r;
  assign wb_rf_wdata      = ld_s ? ld_data_s : ex_result_r;
  assign wb_hi_we         = hi_we_r & ~stallreq_s;
  assign wb_lo_we         = lo_we_r & ~stallreq_s;

endmodule
